// File: rtl/oam_dma_engine.sv
// Sprite-attribute DMA: a CPU write to TRIGGER_ADDR stalls the CPU and copies
// XFER_LEN bytes from page {cpu_data, 8'h00} to the fixed DEST_ADDR port.
module oam_dma_engine #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                XFER_LEN     = 256,
  parameter logic [ADDR_W-1:0] TRIGGER_ADDR = ADDR_W'(16'h4014),
  parameter logic [ADDR_W-1:0] DEST_ADDR    = ADDR_W'(16'h2004),
  parameter bit                ALIGN_EN     = 1'b1,
  localparam int               IDX_W        = $clog2(XFER_LEN),
  localparam int               CNT_W        = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_grant,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_we,
  output logic [DATA_W-1:0] dma_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int SRC_W = (DATA_W + 8 > ADDR_W) ? DATA_W + 8 : ADDR_W;

  state_e            state_q, state_d;
  logic              parity_q;
  logic              extra_q, extra_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SRC_W-1:0]  src_full;
  logic              trigger;

  // Source address is computed wide and truncated so page overflow wraps.
  assign src_full = SRC_W'({page_q, 8'h00}) + SRC_W'(idx_q);
  assign trigger  = cpu_we && (cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      extra_q  <= 1'b0;
      page_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      extra_q  <= extra_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    extra_d   = extra_q;
    page_d    = page_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bus_grant = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          page_d  = cpu_data;
          idx_d   = '0;
          cnt_d   = '0;
          extra_d = ALIGN_EN && parity_q;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        bus_grant = 1'b1;
        busy      = 1'b1;
        // Odd-parity starts spend one more cycle here before the first read.
        if (extra_q) begin
          extra_d = 1'b0;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        bus_grant = 1'b1;
        busy      = 1'b1;
        dma_addr  = src_full[ADDR_W-1:0];
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        bus_grant = 1'b1;
        busy      = 1'b1;
        dma_addr  = DEST_ADDR;
        dma_we    = 1'b1;
        dma_wdata = mem_rdata;
        idx_d     = idx_q + IDX_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = (cnt_q == CNT_W'(XFER_LEN - 1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_rdy    = ~busy;
  assign xfer_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: three instances (defaults, ALIGN_EN=0, 4-byte 8-bit
// address) share stimulus; a cycle-offset model predicts every output each cycle.
module tb_oam_dma_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;

  logic [7:0]  mrd_a, mrd_b, mrd_c;
  logic        grant_a, rdy_a, we_a, busy_a, done_a;
  logic        grant_b, rdy_b, we_b, busy_b, done_b;
  logic        grant_c, rdy_c, we_c, busy_c, done_c;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  addr_c;
  logic [7:0]  wd_a, wd_b, wd_c;
  logic [8:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic [2:0]  st_a, st_b, st_c;

  oam_dma_engine u_a (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_we(cpu_we), .mem_rdata(mrd_a), .bus_grant(grant_a), .cpu_rdy(rdy_a),
    .dma_addr(addr_a), .dma_we(we_a), .dma_wdata(wd_a), .busy(busy_a),
    .done(done_a), .xfer_count(cnt_a), .dbg_state(st_a)
  );

  oam_dma_engine #(.ALIGN_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_we(cpu_we), .mem_rdata(mrd_b), .bus_grant(grant_b), .cpu_rdy(rdy_b),
    .dma_addr(addr_b), .dma_we(we_b), .dma_wdata(wd_b), .busy(busy_b),
    .done(done_b), .xfer_count(cnt_b), .dbg_state(st_b)
  );

  oam_dma_engine #(.ADDR_W(8), .XFER_LEN(4), .TRIGGER_ADDR(8'h14),
                   .DEST_ADDR(8'h04)) u_c (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr[7:0]), .cpu_data(cpu_data),
    .cpu_we(cpu_we), .mem_rdata(mrd_c), .bus_grant(grant_c), .cpu_rdy(rdy_c),
    .dma_addr(addr_c), .dma_we(we_c), .dma_wdata(wd_c), .busy(busy_c),
    .done(done_c), .xfer_count(cnt_c), .dbg_state(st_c)
  );

  // Synchronous source memory with a fixed content pattern.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    mrd_a <= mem_f(addr_a);
    mrd_b <= mem_f(addr_b);
    mrd_c <= mem_f({8'h00, addr_c});
  end

  // Packed output view: {grant, rdy, busy, done, we, addr[15:0], wdata[7:0], cnt[8:0]}
  logic [37:0] act [3];
  assign act[0] = {grant_a, rdy_a, busy_a, done_a, we_a, addr_a, wd_a, cnt_a};
  assign act[1] = {grant_b, rdy_b, busy_b, done_b, we_b, addr_b, wd_b, cnt_b};
  assign act[2] = {grant_c, rdy_c, busy_c, done_c, we_c, 8'h00, addr_c, wd_c, 6'h00, cnt_c};

  localparam logic [37:0] RST_V = {1'b0, 1'b1, 36'h0};

  // ---------------- model ----------------
  int          n_len [3] = '{256, 256, 4};
  bit          aen   [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] amask [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
  logic [15:0] dest  [3] = '{16'h2004, 16'h2004, 16'h0004};

  bit          m_active [3];
  int          m_k      [3];
  int          m_al     [3];
  logic [7:0]  m_page   [3];
  bit          m_par;

  // m_k is the number of cycles since the first busy cycle of the transfer.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_par = 1'b0;
      for (int d = 0; d < 3; d++) m_active[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if ((!m_active[d] || m_k[d] > m_al[d] + 2 * n_len[d]) && cpu_we &&
            ((cpu_addr & amask[d]) == (16'h4014 & amask[d]))) begin
          m_active[d] = 1'b1;
          m_k[d]      = 0;
          m_page[d]   = cpu_data;
          m_al[d]     = (aen[d] && m_par) ? 2 : 1;
        end else if (m_active[d]) begin
          m_k[d] = m_k[d] + 1;
        end
      end
      m_par = !m_par;
    end
  end

  function automatic logic [37:0] expect_vec(input int d);
    logic g, r, b, dn, w;
    logic [15:0] ad, src;
    logic [7:0] wd;
    int k, al, n, c, j;
    g = 0; b = 0; dn = 0; w = 0; ad = '0; wd = '0; c = 0;
    if (m_active[d]) begin
      k = m_k[d]; al = m_al[d]; n = n_len[d];
      if (k >= al) c = ((k - al) / 2 < n) ? (k - al) / 2 : n;
      if (k < al) begin
        g = 1; b = 1;
      end else if (k < al + 2 * n) begin
        j   = (k - al) / 2;
        src = 16'(m_page[d] * 256 + j) & amask[d];
        g = 1; b = 1;
        if (((k - al) % 2) == 0) ad = src;
        else begin
          ad = dest[d]; w = 1; wd = mem_f(src);
        end
      end else if (k == al + 2 * n) begin
        dn = 1;
      end
    end
    r = !b;
    return {g, r, b, dn, w, ad, wd, 9'(c)};
  endfunction

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [37:0] e;
      e = expect_vec(d);
      n_assert++;
      if (act[d] !== e) begin
        n_fail++;
        $display("FAIL cycle_check dut%0d t=%0t got=%h exp=%h", d, $time, act[d], e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int          run [3], last_stall [3], done_cnt [3], wr_cnt [3];
  logic [15:0] prev_addr [3];
  int          rd_cnt_a, rd_bad_a;
  logic [7:0]  exp_page_a;
  logic [15:0] rdq_c [$];

  initial begin
    for (int d = 0; d < 3; d++) begin
      run[d] = 0; last_stall[d] = 0; done_cnt[d] = 0; wr_cnt[d] = 0; prev_addr[d] = '0;
    end
    rd_cnt_a = 0; rd_bad_a = 0; exp_page_a = 8'h00;
  end

  // A write cycle always follows its read, so the previous address is the source.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!act[d][36]) run[d]++;
      else if (run[d] > 0) begin
        last_stall[d] = run[d];
        run[d] = 0;
      end
      if (act[d][34]) done_cnt[d]++;
      if (act[d][33]) begin
        wr_cnt[d]++;
        if (d == 0) begin
          rd_cnt_a++;
          if (prev_addr[0][15:8] != exp_page_a) rd_bad_a++;
        end
        if (d == 2) rdq_c.push_back(prev_addr[2]);
      end
      prev_addr[d] = act[d][32:17];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] dat, input int want_par);
    @(negedge clk);
    while (want_par >= 0 && int'(m_par) != want_par) @(negedge clk);
    #1 cpu_addr = a; cpu_data = dat; cpu_we = 1'b1;
    @(negedge clk);
    #1 cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while ((busy_a || busy_b || busy_c) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_assert++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d cycles exp=<3000", nm, t);
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int snap_rd, snap_bad, snap_wr, t;

  initial begin
    cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0; reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("reset_a", act[0], RST_V);
    chk("reset_b", act[1], RST_V);
    chk("reset_c", act[2], RST_V);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Non-trigger address
    cpu_write(16'h4015, 8'h02, -1);
    repeat (4) @(negedge clk);
    chk("notrig_busy", busy_a, 1'b0);
    chk("notrig_rdy", rdy_a, 1'b1);
    chk("notrig_busy_c", busy_c, 1'b0);

    // Page 02 at parity 0
    exp_page_a = 8'h02; snap_rd = rd_cnt_a; snap_bad = rd_bad_a;
    cpu_write(16'h4014, 8'h02, 0);
    wait_idle("xfer_p0");
    chk("stall_p0_a", last_stall[0], 513);
    chk("stall_p0_b", last_stall[1], 513);
    chk("stall_p0_c", last_stall[2], 9);
    chk("count_p0_a", cnt_a, 256);
    chk("done_p0_a", done_cnt[0], 1);
    chk("reads_p0_a", rd_cnt_a - snap_rd, 256);
    chk("range_p0_a", rd_bad_a - snap_bad, 0);

    // Page 02 at parity 1
    cpu_write(16'h4014, 8'h02, 1);
    wait_idle("xfer_p1");
    chk("stall_p1_a", last_stall[0], 514);
    chk("stall_p1_b", last_stall[1], 513);
    chk("done_p1_a", done_cnt[0], 2);

    // Page 07 with an ignored retrigger to page 03
    exp_page_a = 8'h07; snap_rd = rd_cnt_a; snap_bad = rd_bad_a;
    cpu_write(16'h4014, 8'h07, -1);
    repeat (20) @(negedge clk);
    cpu_write(16'h4014, 8'h03, -1);
    wait_idle("xfer_retrig");
    chk("range_p7_a", rd_bad_a - snap_bad, 0);
    chk("reads_p7_a", rd_cnt_a - snap_rd, 256);
    chk("done_p7_a", done_cnt[0], 3);
    chk("done_p7_b", done_cnt[1], 3);

    // Reset after the 10th write
    exp_page_a = 8'h05; snap_wr = wr_cnt[0];
    cpu_write(16'h4014, 8'h05, -1);
    t = 0;
    while (wr_cnt[0] - snap_wr < 10 && t < 200) begin
      @(negedge clk); #1; t++;
    end
    chk("ten_writes", wr_cnt[0] - snap_wr, 10);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_a", act[0], RST_V);
    chk("async_rst_b", act[1], RST_V);
    chk("async_rst_c", act[2], RST_V);
    @(negedge clk);
    #1 reset = 1'b0; cpu_addr = 16'h4014; cpu_data = 8'h01; cpu_we = 1'b1;
    exp_page_a = 8'h01; snap_rd = rd_cnt_a; snap_bad = rd_bad_a;
    @(negedge clk);
    #1 cpu_addr = '0; cpu_data = '0; cpu_we = 1'b0;
    wait_idle("xfer_after_rst");
    chk("done_rst_a", done_cnt[0], 4);
    chk("stall_rst_a", last_stall[0], 513);
    chk("reads_rst_a", rd_cnt_a - snap_rd, 256);
    chk("range_rst_a", rd_bad_a - snap_bad, 0);

    // Page FF: wraps to 0x00.. on the 8-bit instance
    rdq_c.delete();
    cpu_write(16'h4014, 8'hFF, 0);
    wait_idle("xfer_ff");
    chk("wrap_c_len", rdq_c.size(), 4);
    for (int i = 0; i < 4 && i < rdq_c.size(); i++)
      chk("wrap_c_addr", rdq_c[i], i);
    chk("stall_ff_c", last_stall[2], 9);
    chk("count_ff_c", cnt_c, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
